// File: rtl/serial_operand_feeder.sv
// serial_operand_feeder: latches an operand pair over valid/ready and streams both words one bit per clock to the bit-serial comparator.
// Ports: clk, rst (async, active-high); in_valid/in_ready handshake with a_in, b_in, msb_first;
// a, b serial bits; op latched bit order; cmp_clr comparator clear pulse; bit_valid, last framing; busy pair in flight.
module serial_operand_feeder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             msb_first,
  output logic             a,
  output logic             b,
  output logic             op,
  output logic             cmp_clr,
  output logic             bit_valid,
  output logic             last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] PEN = CW'(WIDTH - 2);
  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CW-1:0] cnt;
  logic xfer, adv;
  always_comb begin
    in_ready = state == IDLE || (state == SHIFT && last);
    xfer = in_valid && in_ready;
    state_n = xfer ? CLEAR : (state == CLEAR || (state == SHIFT && !last)) ? SHIFT : IDLE;
    adv = state_n == SHIFT;
  end
  // The shift registers always hold the next bit to emit at their emitting end;
  // outputs are registered from the next-state decision so they align with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sh_a      <= '0;
      sh_b      <= '0;
      cnt       <= '0;
      op        <= 1'b0;
      a         <= 1'b0;
      b         <= 1'b0;
      cmp_clr   <= 1'b0;
      bit_valid <= 1'b0;
      last      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state <= state_n;
      if (xfer) begin
        sh_a <= a_in;
        sh_b <= b_in;
        op   <= msb_first;
      end else if (adv) begin
        sh_a <= op ? sh_a << 1 : sh_a >> 1;
        sh_b <= op ? sh_b << 1 : sh_b >> 1;
      end
      a         <= adv && (op ? sh_a[WIDTH-1] : sh_a[0]);
      b         <= adv && (op ? sh_b[WIDTH-1] : sh_b[0]);
      cnt       <= (adv && state == SHIFT) ? cnt + 1'b1 : '0;
      last      <= adv && state == SHIFT && cnt == PEN;
      cmp_clr   <= state_n == CLEAR;
      bit_valid <= adv;
      busy      <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_serial_operand_feeder.sv
// tb_serial_operand_feeder: scoreboard bench for the 32-bit and 4-bit feeder instances.
module tb_serial_operand_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        in_valid = 1'b0, msb_first = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;
  logic        in_ready, a, b, op, cmp_clr, bit_valid, last, busy;
  logic        v4 = 1'b0, m4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        r4, a_o4, b_o4, op4, clr4, bv4, last4, busy4;
  serial_operand_feeder #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .msb_first(msb_first), .a(a), .b(b), .op(op), .cmp_clr(cmp_clr), .bit_valid(bit_valid),
    .last(last), .busy(busy));
  serial_operand_feeder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .a_in(a4), .b_in(b4),
    .msb_first(m4), .a(a_o4), .b(b_o4), .op(op4), .cmp_clr(clr4), .bit_valid(bv4),
    .last(last4), .busy(busy4));
  typedef struct packed {logic a; logic b; logic last; logic op;} bit_t;
  bit_t q32[$], q4[$];
  int n_checks = 0, n_fail = 0;
  logic g = 1'b0, l = 1'b0, dec = 1'b0;
  always @(posedge clk) begin
    if (rst || cmp_clr) begin
      g <= 1'b0; l <= 1'b0; dec <= 1'b0;
    end else if (bit_valid && a != b) begin
      if (!op) begin
        g <= a; l <= b;
      end else if (!dec) begin
        g <= a; l <= b; dec <= 1'b1;
      end
    end
  end
  task automatic cyc();
    bit_t e;
    @(negedge clk);
    n_checks++;
    if (bit_valid) begin
      if (q32.size() == 0) begin
        n_fail++; $display("FAIL sb32 extra bit: got a=%b b=%b, required no bit", a, b);
      end else begin
        e = q32.pop_front();
        if ({a, b, last, op} !== e) begin
          n_fail++; $display("FAIL sb32 bit: got a/b/last/op=%b required %b", {a, b, last, op}, e);
        end
      end
    end else if ({a, b, last} !== 3'b000) begin
      n_fail++; $display("FAIL sb32 idle outputs: got a/b/last=%b required 000", {a, b, last});
    end
    n_checks++;
    if (bv4) begin
      if (q4.size() == 0) begin
        n_fail++; $display("FAIL sb4 extra bit: got a=%b b=%b, required no bit", a_o4, b_o4);
      end else begin
        e = q4.pop_front();
        if ({a_o4, b_o4, last4, op4} !== e) begin
          n_fail++; $display("FAIL sb4 bit: got a/b/last/op=%b required %b", {a_o4, b_o4, last4, op4}, e);
        end
      end
    end else if ({a_o4, b_o4, last4} !== 3'b000) begin
      n_fail++; $display("FAIL sb4 idle outputs: got a/b/last=%b required 000", {a_o4, b_o4, last4});
    end
  endtask
  task automatic push(input bit w4, input logic [31:0] av, input logic [31:0] bv, input logic m);
    int w;
    w = w4 ? 4 : 32;
    for (int i = 0; i < w; i++) begin
      int k;
      bit_t e;
      k = m ? w - 1 - i : i;
      e = {av[k], bv[k], i == w - 1, m};
      if (w4) q4.push_back(e);
      else q32.push_back(e);
    end
  endtask
  task automatic send(input bit w4, input logic [31:0] av, input logic [31:0] bv, input logic m);
    if (w4) begin a4 = av[3:0]; b4 = bv[3:0]; m4 = m; v4 = 1'b1; end
    else begin a_in = av; b_in = bv; msb_first = m; in_valid = 1'b1; end
    for (int t = 0; t < 200; t++) begin
      if (w4 ? r4 : in_ready) begin
        push(w4, av, bv, m);
        cyc();
        v4 = 1'b0;
        in_valid = 1'b0;
        return;
      end
      cyc();
    end
    n_checks++; n_fail++;
    $display("FAIL send timeout: got in_ready=0 for 200 cycles, required 1");
    v4 = 1'b0;
    in_valid = 1'b0;
  endtask
  task automatic wait_idle(input bit w4);
    for (int t = 0; t < 100; t++) begin
      if (!(w4 ? busy4 : busy)) break;
      cyc();
    end
    n_checks++;
    if (w4 ? busy4 : busy) begin
      n_fail++; $display("FAIL idle timeout: got busy=1, required 0");
    end
    n_checks++;
    if ((w4 ? q4.size() : q32.size()) != 0) begin
      n_fail++; $display("FAIL missing bits: got %0d unconsumed, required 0", w4 ? q4.size() : q32.size());
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    n_checks++;
    if ({a, b, op, cmp_clr, bit_valid, last, busy, in_ready} !== 8'b0000_0001) begin
      n_fail++; $display("FAIL reset32: got %b required 00000001", {a, b, op, cmp_clr, bit_valid, last, busy, in_ready});
    end
    n_checks++;
    if ({a_o4, b_o4, op4, clr4, bv4, last4, busy4, r4} !== 8'b0000_0001) begin
      n_fail++; $display("FAIL reset4: got %b required 00000001", {a_o4, b_o4, op4, clr4, bv4, last4, busy4, r4});
    end
    rst = 1'b0;
    cyc();
  endtask
  task automatic test_order(input logic m);
    send(1'b0, 32'd124, 32'd123, m);
    n_checks++;
    if ({cmp_clr, busy, bit_valid, op} !== {3'b110, m}) begin
      n_fail++; $display("FAIL clear cycle: got clr/busy/bv/op=%b required %b", {cmp_clr, busy, bit_valid, op}, {3'b110, m});
    end
    cyc();
    n_checks++;
    if ({cmp_clr, bit_valid} !== 2'b01) begin
      n_fail++; $display("FAIL first bit: got clr/bv=%b required 01", {cmp_clr, bit_valid});
    end
    wait_idle(1'b0);
    n_checks++;
    if ({g, l, op} !== {2'b10, m}) begin
      n_fail++; $display("FAIL compare 124 vs 123: got G/L/op=%b required %b", {g, l, op}, {2'b10, m});
    end
  endtask
  task automatic test_back_to_back();
    int c2, rdy, gap;
    bit drop;
    c2 = -1; rdy = 0; gap = 0; drop = 1'b0;
    send(1'b0, 32'd5, 32'd5, 1'b0);
    a_in = 32'd0; b_in = 32'd7; msb_first = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 60 && c2 < 0; i++) begin
      if (in_valid && in_ready) begin
        rdy++;
        n_checks++;
        if (!(last && i == 32)) begin
          n_fail++; $display("FAIL b2b ready: got ready at cycle %0d last=%b, required cycle 32 last=1", i, last);
        end
        push(1'b0, 32'd0, 32'd7, 1'b0);
        drop = 1'b1;
      end
      cyc();
      if (drop) in_valid = 1'b0;
      if (!busy) gap++;
      if (cmp_clr) c2 = i + 1;
    end
    n_checks++;
    if (rdy != 1) begin
      n_fail++; $display("FAIL b2b ready count: got %0d required 1", rdy);
    end
    n_checks++;
    if (c2 != 33) begin
      n_fail++; $display("FAIL b2b period: got %0d required 33", c2);
    end
    n_checks++;
    if (gap != 0) begin
      n_fail++; $display("FAIL b2b idle gap: got %0d idle cycles required 0", gap);
    end
    in_valid = 1'b0;
    wait_idle(1'b0);
  endtask
  task automatic test_stall();
    bit acc;
    acc = 1'b0;
    send(1'b0, 32'h1234_5678, 32'h8765_4321, 1'b1);
    repeat (11) cyc();
    a_in = 32'hFFFF_FFFF; b_in = 32'd0; msb_first = 1'b0; in_valid = 1'b1;
    for (int i = 11; i < 40; i++) begin
      if (in_ready) begin
        n_checks++;
        if (!(last && i == 32)) begin
          n_fail++; $display("FAIL stall ready: got ready at cycle %0d, required cycle 32", i);
        end
        push(1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        acc = 1'b1;
        cyc();
        in_valid = 1'b0;
        break;
      end
      cyc();
    end
    in_valid = 1'b0;
    n_checks++;
    if (!acc) begin
      n_fail++; $display("FAIL stall accept: got no transfer, required transfer at last");
    end
    wait_idle(1'b0);
  endtask
  task automatic test_async_reset();
    send(1'b0, 32'hA5A5_0F0F, 32'h0F0F_A5A5, 1'b0);
    repeat (11) cyc();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({a, b, op, cmp_clr, bit_valid, last, busy, in_ready} !== 8'b0000_0001) begin
      n_fail++; $display("FAIL async reset: got %b required 00000001", {a, b, op, cmp_clr, bit_valid, last, busy, in_ready});
    end
    q32.delete();
    repeat (2) cyc();
    rst = 1'b0;
    repeat (2) cyc();
    n_checks++;
    if ({busy, cmp_clr} !== 2'b00) begin
      n_fail++; $display("FAIL no resume: got busy/clr=%b required 00", {busy, cmp_clr});
    end
    send(1'b0, 32'd3, 32'd2, 1'b0);
    wait_idle(1'b0);
  endtask
  task automatic test_width4();
    send(1'b1, 32'hF, 32'h0, 1'b0);
    n_checks++;
    if (clr4 !== 1'b1) begin
      n_fail++; $display("FAIL w4 clear: got %b required 1", clr4);
    end
    repeat (5) cyc();
    n_checks++;
    if ({busy4, bv4, last4} !== 3'b000) begin
      n_fail++; $display("FAIL w4 idle: got busy/bv/last=%b required 000", {busy4, bv4, last4});
    end
    wait_idle(1'b1);
  endtask
  initial begin
    test_reset();
    test_order(1'b0);
    test_order(1'b1);
    test_back_to_back();
    test_stall();
    test_async_reset();
    test_width4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
